// File: rtl/ram_loader.sv
// ram_loader: receives a byte stream made of a 16-bit big-endian word count
// followed by that many big-endian 16-bit words, and writes each word to
// consecutive RAM addresses starting at BASE_ADDR. Tracks words written and a
// running 16-bit checksum, and aborts to ERROR on an oversize count or when
// the sender stalls for TIMEOUT_CYCLES.
//
// Handshake: a byte moves on a rising clock edge only when rx_valid and
// rx_ready are both high; rx_ready is high only in LEN_HI, LEN_LO, DATA_HI and
// DATA_LO, and the sender may hold rx_valid/rx_data for as long as it likes.
module ram_loader #(
    parameter int BASE_ADDR      = 0,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [15:0] ram_in,
    output logic [13:0] ram_addr,
    output logic        ram_load,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [14:0] words_written,
    output logic [15:0] checksum,
    output logic [3:0]  dbg_state
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        LEN_HI  = 4'd1,
        LEN_LO  = 4'd2,
        DATA_HI = 4'd3,
        DATA_LO = 4'd4,
        WRITE   = 4'd5,
        DONE    = 4'd6,
        ERROR   = 4'd7
    } state_t;

    localparam int              IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [13:0]     BASE      = 14'(BASE_ADDR);
    localparam logic [15:0]     MAX_WORDS = 16'd16384;

    state_t            state_q;
    logic [7:0]        len_hi_q;
    logic [15:0]       len_q;
    logic [7:0]        data_hi_q;
    logic [13:0]       addr_q;
    logic [IDLE_W-1:0] idle_q;
    logic [15:0]       ram_in_q;
    logic [13:0]       ram_addr_q;
    logic              ram_load_q;
    logic              rx_ready_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;
    logic [14:0]       words_q;
    logic [15:0]       checksum_q;

    logic              xfer_d;
    logic [15:0]       len_d;
    logic [15:0]       word_d;
    logic [14:0]       words_d;
    logic              last_word_d;
    logic              timeout_d;

    // Byte-level helpers shared by the state machine.
    always_comb begin
        xfer_d      = rx_valid & rx_ready_q;
        len_d       = {len_hi_q, rx_data};
        word_d      = {data_hi_q, rx_data};
        words_d     = words_q + 15'd1;
        last_word_d = ({1'b0, words_d} == len_q);
        timeout_d   = (idle_q == IDLE_LAST);
    end

    // Load-session state machine with registered handshake and status outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            len_hi_q   <= '0;
            len_q      <= '0;
            data_hi_q  <= '0;
            addr_q     <= '0;
            idle_q     <= '0;
            ram_in_q   <= '0;
            ram_addr_q <= '0;
            ram_load_q <= 1'b0;
            rx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            words_q    <= '0;
            checksum_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state_q    <= LEN_HI;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                        words_q    <= '0;
                        checksum_q <= '0;
                        addr_q     <= BASE;
                        idle_q     <= '0;
                        rx_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end

                LEN_HI, LEN_LO, DATA_HI, DATA_LO: begin
                    if (!xfer_d) begin
                        // Sender stalled: count idle cycles, abort on the limit.
                        if (timeout_d) begin
                            state_q    <= ERROR;
                            error_q    <= 1'b1;
                            busy_q     <= 1'b0;
                            rx_ready_q <= 1'b0;
                            idle_q     <= '0;
                        end else begin
                            idle_q <= idle_q + IDLE_W'(1);
                        end
                    end else begin
                        idle_q <= '0;
                        case (state_q)
                            LEN_HI: begin
                                len_hi_q <= rx_data;
                                state_q  <= LEN_LO;
                            end
                            LEN_LO: begin
                                len_q <= len_d;
                                if (len_d == 16'd0) begin
                                    state_q    <= DONE;
                                    done_q     <= 1'b1;
                                    busy_q     <= 1'b0;
                                    rx_ready_q <= 1'b0;
                                end else if (len_d > MAX_WORDS) begin
                                    state_q    <= ERROR;
                                    error_q    <= 1'b1;
                                    busy_q     <= 1'b0;
                                    rx_ready_q <= 1'b0;
                                end else begin
                                    state_q <= DATA_HI;
                                end
                            end
                            DATA_HI: begin
                                data_hi_q <= rx_data;
                                state_q   <= DATA_LO;
                            end
                            default: begin
                                // DATA_LO: word complete, present it for one write cycle.
                                state_q    <= WRITE;
                                ram_load_q <= 1'b1;
                                ram_in_q   <= word_d;
                                ram_addr_q <= addr_q;
                                rx_ready_q <= 1'b0;
                            end
                        endcase
                    end
                end

                WRITE: begin
                    ram_load_q <= 1'b0;
                    addr_q     <= addr_q + 14'd1;
                    words_q    <= words_d;
                    checksum_q <= checksum_q + ram_in_q;
                    idle_q     <= '0;
                    if (last_word_d) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q    <= DATA_HI;
                        rx_ready_q <= 1'b1;
                    end
                end

                default: begin
                    state_q    <= IDLE;
                    ram_load_q <= 1'b0;
                    rx_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign rx_ready      = rx_ready_q;
    assign ram_in        = ram_in_q;
    assign ram_addr      = ram_addr_q;
    assign ram_load      = ram_load_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign words_written = words_q;
    assign checksum      = checksum_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: two instances (base 0 and base 16383, short timeout)
// share one byte stream; a session-level model predicts writes and results.
module tb_ram_loader;

    localparam int TMO = 16;

    logic        clock    = 1'b0;
    logic        reset_n  = 1'b1;
    logic        start    = 1'b0;
    logic [7:0]  rx_data  = 8'h00;
    logic        rx_valid = 1'b0;

    logic        rx_ready      [2];
    logic [15:0] ram_in        [2];
    logic [13:0] ram_addr      [2];
    logic        ram_load      [2];
    logic        busy          [2];
    logic        done          [2];
    logic        error         [2];
    logic [14:0] words_written [2];
    logic [15:0] checksum      [2];
    logic [3:0]  dbg_state     [2];

    // Clock: 10 time-unit period.
    always #5 clock = ~clock;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ram_loader #(
            .BASE_ADDR      (g == 0 ? 0 : 16383),
            .TIMEOUT_CYCLES (TMO)
        ) dut (
            .clock         (clock),
            .reset_n       (reset_n),
            .start         (start),
            .rx_data       (rx_data),
            .rx_valid      (rx_valid),
            .rx_ready      (rx_ready[g]),
            .ram_in        (ram_in[g]),
            .ram_addr      (ram_addr[g]),
            .ram_load      (ram_load[g]),
            .busy          (busy[g]),
            .done          (done[g]),
            .error         (error[g]),
            .words_written (words_written[g]),
            .checksum      (checksum[g]),
            .dbg_state     (dbg_state[g])
        );
    end

    // Scoreboard: expected writes as {word index in session, data}.
    logic [29:0] exp_q [$];
    logic [7:0]  stim_q [$];
    int          rd_ptr [2];
    int          base_of [2];
    logic [15:0] hold_in [2];
    logic [13:0] hold_addr [2];
    int          checks = 0;
    int          failures = 0;

    logic [15:0] m_n;
    int          m_words;
    logic [15:0] m_cs;
    logic        m_done;
    logic        m_error;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Session model: parse count and complete words straight from the byte list.
    task automatic model_session();
        int nb;
        logic [15:0] w;
        nb      = stim_q.size();
        m_n     = {stim_q[0], stim_q[1]};
        m_words = 0;
        m_cs    = 16'h0000;
        if (m_n <= 16'd16384) begin
            for (int i = 0; i < int'(m_n) && (3 + 2 * i) < nb; i++) begin
                w = {stim_q[2 + 2 * i], stim_q[3 + 2 * i]};
                exp_q.push_back({14'(i), w});
                m_cs = m_cs + w;
                m_words++;
            end
        end
        m_done  = (m_n == 16'd0) || (m_n <= 16'd16384 && m_words == int'(m_n));
        m_error = !m_done;
    endtask

    // Compare process: every write and every held output, each cycle.
    always @(negedge clock) begin
        if (reset_n) begin
            for (int g = 0; g < 2; g++) begin
                logic [29:0] e;
                logic [13:0] ea;
                if (ram_load[g] === 1'b1) begin
                    check("write_expected", 32'(rd_ptr[g] < exp_q.size()), 32'd1);
                    if (rd_ptr[g] < exp_q.size()) begin
                        e  = exp_q[rd_ptr[g]];
                        ea = 14'((base_of[g] + int'(e[29:16])) % 16384);
                        check("write_addr", 32'(ram_addr[g]), 32'(ea));
                        check("write_data", 32'(ram_in[g]), 32'(e[15:0]));
                        check("write_busy", 32'(busy[g]), 32'd1);
                        check("write_rdy_low", 32'(rx_ready[g]), 32'd0);
                        hold_in[g]   = e[15:0];
                        hold_addr[g] = ea;
                        rd_ptr[g]++;
                    end
                end else begin
                    check("hold_ram_in", 32'(ram_in[g]), 32'(hold_in[g]));
                    check("hold_ram_addr", 32'(ram_addr[g]), 32'(hold_addr[g]));
                end
                check("rdy_implies_busy", 32'(rx_ready[g] & ~busy[g]), 32'd0);
                check("busy_excl_flags", 32'(busy[g] & (done[g] | error[g])), 32'd0);
                check("done_err_excl", 32'(done[g] & error[g]), 32'd0);
            end
            check("lockstep_state", 32'(dbg_state[1]), 32'(dbg_state[0]));
        end
    end

    task automatic check_all_zero(input string tag);
        for (int g = 0; g < 2; g++) begin
            check({tag, "_rx_ready"}, 32'(rx_ready[g]), 32'd0);
            check({tag, "_ram_load"}, 32'(ram_load[g]), 32'd0);
            check({tag, "_busy"}, 32'(busy[g]), 32'd0);
            check({tag, "_done"}, 32'(done[g]), 32'd0);
            check({tag, "_error"}, 32'(error[g]), 32'd0);
            check({tag, "_ram_in"}, 32'(ram_in[g]), 32'd0);
            check({tag, "_ram_addr"}, 32'(ram_addr[g]), 32'd0);
            check({tag, "_words"}, 32'(words_written[g]), 32'd0);
            check({tag, "_checksum"}, 32'(checksum[g]), 32'd0);
        end
    endtask

    task automatic do_reset(input string tag);
        #2 reset_n = 1'b0;
        #1 check_all_zero(tag);
        for (int g = 0; g < 2; g++) begin
            rd_ptr[g]    = exp_q.size();
            hold_in[g]   = 16'h0000;
            hold_addr[g] = 14'h0000;
        end
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic do_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int g = 0; g < 2; g++) begin
            check("start_busy", 32'(busy[g]), 32'd1);
            check("start_rdy", 32'(rx_ready[g]), 32'd1);
            check("start_done_clr", 32'(done[g]), 32'd0);
            check("start_err_clr", 32'(error[g]), 32'd0);
            check("start_words_clr", 32'(words_written[g]), 32'd0);
            check("start_cs_clr", 32'(checksum[g]), 32'd0);
        end
    endtask

    // Begins and ends at a falling edge; the handshake edge lies in between.
    task automatic send_byte(input logic [7:0] b);
        int t;
        rx_data  = b;
        rx_valid = 1'b1;
        t = 0;
        while (rx_ready[0] !== 1'b1 && t < 40) begin
            @(negedge clock);
            t++;
        end
        check("rx_ready_wait", 32'(t < 40), 32'd1);
        @(negedge clock);
    endtask

    task automatic check_results(input string tag);
        for (int g = 0; g < 2; g++) begin
            check({tag, "_done"}, 32'(done[g]), 32'(m_done));
            check({tag, "_error"}, 32'(error[g]), 32'(m_error));
            check({tag, "_busy"}, 32'(busy[g]), 32'd0);
            check({tag, "_words"}, 32'(words_written[g]), 32'(m_words));
            check({tag, "_checksum"}, 32'(checksum[g]), 32'(m_cs));
            check({tag, "_all_written"}, 32'(rd_ptr[g]), 32'(exp_q.size()));
        end
    endtask

    task automatic run_session(input string tag);
        int t;
        model_session();
        do_start();
        foreach (stim_q[i]) send_byte(stim_q[i]);
        rx_valid = 1'b0;
        if (m_n == 16'd0 || m_n > 16'd16384) begin
            for (int g = 0; g < 2; g++) begin
                check({tag, "_lat_done"}, 32'(done[g]), 32'(m_done));
                check({tag, "_lat_error"}, 32'(error[g]), 32'(m_error));
                check({tag, "_no_load"}, 32'(ram_load[g]), 32'd0);
            end
        end else if (m_done) begin
            for (int g = 0; g < 2; g++) begin
                check({tag, "_lat_load"}, 32'(ram_load[g]), 32'd1);
                check({tag, "_lat_done_early"}, 32'(done[g]), 32'd0);
            end
            @(negedge clock);
            for (int g = 0; g < 2; g++) begin
                check({tag, "_lat_done"}, 32'(done[g]), 32'd1);
                check({tag, "_lat_load_off"}, 32'(ram_load[g]), 32'd0);
            end
        end
        t = 0;
        while (!(done[0] | error[0]) && t < 60) begin
            @(negedge clock);
            t++;
        end
        check({tag, "_finish_wait"}, 32'(t < 60), 32'd1);
        check_results(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        base_of[0] = 0;
        base_of[1] = 16383;
        for (int g = 0; g < 2; g++) begin
            rd_ptr[g]    = 0;
            hold_in[g]   = 16'h0000;
            hold_addr[g] = 14'h0000;
        end

        do_reset("por");

        // Two words at base; addresses wrap on the 16383 instance.
        stim_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        run_session("two_words");
        check("two_words_model_cs", 32'(m_cs), 32'h0000BE01);
        check("two_words_cs_lit", 32'(checksum[0]), 32'h0000BE01);
        check("two_words_ww_lit", 32'(words_written[0]), 32'd2);
        check("two_words_addr0_lit", 32'(ram_addr[0]), 32'd1);
        check("two_words_data_lit", 32'(ram_in[0]), 32'h0000ABCD);
        check("two_words_addr1_lit", 32'(ram_addr[1]), 32'd0);

        // Zero-length session.
        stim_q = '{8'h00, 8'h00};
        run_session("zero_len");
        check("zero_len_cs_lit", 32'(checksum[0]), 32'd0);

        // Oversize count.
        stim_q = '{8'h40, 8'h01};
        run_session("oversize");
        check("oversize_err_lit", 32'(error[0]), 32'd1);

        // Maximum legal count is accepted; the sender then stalls.
        stim_q = '{8'h40, 8'h00, 8'h01, 8'h02};
        run_session("max_len");
        check("max_len_ww_lit", 32'(words_written[0]), 32'd1);

        // Wrap case for the base-16383 instance.
        stim_q = '{8'h00, 8'h02, 8'hFF, 8'hFF, 8'h00, 8'h02};
        run_session("wrap");
        check("wrap_model_cs", 32'(m_cs), 32'h00000001);
        check("wrap_cs_lit", 32'(checksum[1]), 32'h00000001);
        check("wrap_addr_lit", 32'(ram_addr[1]), 32'd0);
        check("wrap_data_lit", 32'(ram_in[1]), 32'h00000002);

        // Carry-out of the checksum.
        stim_q = '{8'h00, 8'h03, 8'h00, 8'h01, 8'h80, 8'h00, 8'hFF, 8'hFF};
        run_session("carry");
        check("carry_cs_lit", 32'(checksum[0]), 32'h00008000);

        // Timeout: exactly TMO idle cycles after the last accepted byte.
        stim_q = '{8'h00, 8'h03, 8'h12};
        model_session();
        do_start();
        foreach (stim_q[i]) send_byte(stim_q[i]);
        rx_valid = 1'b0;
        for (int k = 1; k <= TMO; k++) begin
            @(negedge clock);
            for (int g = 0; g < 2; g++) begin
                check("timeout_error", 32'(error[g]), 32'(k == TMO));
                check("timeout_busy", 32'(busy[g]), 32'(k != TMO));
            end
        end
        check_results("timeout");

        // Reset mid-session after the first write, then a fresh session.
        stim_q = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
        model_session();
        do_start();
        foreach (stim_q[i]) send_byte(stim_q[i]);
        rx_valid = 1'b0;
        @(negedge clock);
        check("abort_one_write", 32'(rd_ptr[0]), 32'(exp_q.size()));
        do_reset("abort");
        repeat (4) @(negedge clock);
        stim_q = '{8'h00, 8'h01, 8'hAA, 8'h55};
        run_session("after_abort");
        check("after_abort_data_lit", 32'(ram_in[0]), 32'h0000AA55);
        check("after_abort_addr_lit", 32'(ram_addr[0]), 32'd0);

        repeat (3) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
